// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
// Imported by the hazard controller, its interface and the load-use detector.
package pipeline_hazard_ctrl_pkg;

    typedef struct packed {
        logic load_pc;
        logic load_if_id;
        logic load_id_ex;
        logic load_ex_mem;
        logic load_mem_wb;
    } stall_load_reg_t;

    localparam logic [0:0] ST_RUN      = 1'b0;
    localparam logic [0:0] ST_MEM_WAIT = 1'b1;

    localparam logic [4:0] LOAD_ALL  = 5'b11111;
    localparam logic [4:0] LOAD_NONE = 5'b00000;
    localparam logic [4:0] LOAD_LU   = 5'b00111;

    localparam logic [4:0] REG_ZERO  = 5'd0;

    // x0 is hardwired, so it never produces a dependency.
    function automatic logic reg_dep(input logic [4:0] rd, input logic [4:0] rs);
        return (rd != REG_ZERO) && (rd == rs);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: cache handshakes, ID/EX register fields in,
// stage load enables, flushes and the timeout flag out.
interface pipeline_hazard_ctrl_if;
    import pipeline_hazard_ctrl_pkg::*;

    logic            icache_read;
    logic            icache_resp;
    logic            dcache_req;
    logic            dcache_resp;
    logic [4:0]      id_rs1;
    logic [4:0]      id_rs2;
    logic [4:0]      ex_rd;
    logic            ex_is_load;
    logic            ex_br_taken;
    stall_load_reg_t load;
    logic            flush_if_id;
    logic            flush_id_ex;
    logic            timeout_err;

    modport master (
        output icache_read, icache_resp, dcache_req, dcache_resp,
        output id_rs1, id_rs2, ex_rd, ex_is_load, ex_br_taken,
        input  load, flush_if_id, flush_id_ex, timeout_err
    );

    modport slave (
        input  icache_read, icache_resp, dcache_req, dcache_resp,
        input  id_rs1, id_rs2, ex_rd, ex_is_load, ex_br_taken,
        output load, flush_if_id, flush_id_ex, timeout_err
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Combinational load-use detector: a load in EX whose rd feeds rs1/rs2 in ID.
// Register equality is checked regardless of instruction format.
module pipeline_hazard_ctrl_load_use_detect
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic [4:0] i_ex_rd,
    input  logic       i_ex_is_load,
    input  logic [4:0] i_id_rs1,
    input  logic [4:0] i_id_rs2,
    output logic       o_hit
);

    assign o_hit = i_ex_is_load & (reg_dep(i_ex_rd, i_id_rs1) | reg_dep(i_ex_rd, i_id_rs2));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer: freezes the pipe on cache waits, bubbles on
// load-use and flushes IF/ID and ID/EX on taken branches (deferred while frozen).
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int STALL_TIMEOUT = 1024
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    pipeline_hazard_ctrl_if.slave  io_hz
);

    localparam int               CNT_W    = $clog2(STALL_TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STALL_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STALL_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [0:0]       r_state;
    logic             r_ic_done;
    logic             r_dc_done;
    logic             r_pend_flush;
    logic             r_timeout_err;
    logic [CNT_W-1:0] r_wait_cnt;

    logic             w_ic_ok;
    logic             w_dc_ok;
    logic             w_mem_ok;
    logic             w_lu_hit;
    logic             w_flush_req;
    logic [4:0]       w_load;
    logic             w_flush_if_id;
    logic             w_flush_id_ex;

    assign w_ic_ok     = !io_hz.icache_read | io_hz.icache_resp | r_ic_done;
    assign w_dc_ok     = !io_hz.dcache_req  | io_hz.dcache_resp | r_dc_done;
    assign w_mem_ok    = w_ic_ok & w_dc_ok;
    assign w_flush_req = io_hz.ex_br_taken | r_pend_flush;

    pipeline_hazard_ctrl_load_use_detect u_load_use (
        .i_ex_rd      (io_hz.ex_rd),
        .i_ex_is_load (io_hz.ex_is_load),
        .i_id_rs1     (io_hz.id_rs1),
        .i_id_rs2     (io_hz.id_rs2),
        .o_hit        (w_lu_hit)
    );

    // Wait FSM, sticky response flags, wait counter and timeout flag.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= ST_RUN;
            r_ic_done     <= 1'b0;
            r_dc_done     <= 1'b0;
            r_wait_cnt    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (!w_mem_ok) begin
                        r_state   <= ST_MEM_WAIT;
                        // A response with no request in flight must not count.
                        r_ic_done <= io_hz.icache_read & io_hz.icache_resp;
                        r_dc_done <= io_hz.dcache_req  & io_hz.dcache_resp;
                    end
                end
                ST_MEM_WAIT: begin
                    if (w_mem_ok) begin
                        r_state    <= ST_RUN;
                        r_ic_done  <= 1'b0;
                        r_dc_done  <= 1'b0;
                        r_wait_cnt <= '0;
                    end else begin
                        r_ic_done <= r_ic_done | io_hz.icache_resp;
                        r_dc_done <= r_dc_done | io_hz.dcache_resp;
                        if (r_wait_cnt != CNT_MAX) begin
                            r_wait_cnt <= r_wait_cnt + CNT_ONE;
                        end
                        if (r_wait_cnt >= CNT_LAST) begin
                            r_timeout_err <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state    <= ST_RUN;
                    r_ic_done  <= 1'b0;
                    r_dc_done  <= 1'b0;
                    r_wait_cnt <= '0;
                end
            endcase
        end
    end

    // Remember a redirect seen while frozen so it is applied on release.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pend_flush <= 1'b0;
        end else if (!w_mem_ok) begin
            if (io_hz.ex_br_taken) begin
                r_pend_flush <= 1'b1;
            end
        end else if (w_flush_req) begin
            r_pend_flush <= 1'b0;
        end
    end

    // Priority output mux: freeze, then redirect flush, then load-use bubble.
    always_comb begin
        w_load        = LOAD_NONE;
        w_flush_if_id = 1'b0;
        w_flush_id_ex = 1'b0;
        if (i_rst) begin
            w_load = LOAD_NONE;
        end else if (!w_mem_ok) begin
            w_load = LOAD_NONE;
        end else if (w_flush_req) begin
            w_load        = LOAD_ALL;
            w_flush_if_id = 1'b1;
            w_flush_id_ex = 1'b1;
        end else if (w_lu_hit) begin
            w_load        = LOAD_LU;
            w_flush_id_ex = 1'b1;
        end else begin
            w_load = LOAD_ALL;
        end
    end

    assign io_hz.load        = stall_load_reg_t'(w_load);
    assign io_hz.flush_if_id = w_flush_if_id;
    assign io_hz.flush_id_ex = w_flush_id_ex;
    assign io_hz.timeout_err = r_timeout_err;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: each step drives one cycle of inputs,
// queues the expected outputs and checks them mid-cycle on the falling edge.
module tb_pipeline_hazard_ctrl;

    typedef struct {
        string      tag;
        logic [4:0] ld;
        logic       fi;
        logic       fe;
        logic       to;
    } exp_t;

    logic   clk;
    logic   rst;
    int     errors;
    int     checks;
    exp_t   sb[$];

    pipeline_hazard_ctrl_if hz ();

    pipeline_hazard_ctrl #(.STALL_TIMEOUT(8)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .io_hz (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // ctl = {icache_read, icache_resp, dcache_req, dcache_resp, ex_is_load, ex_br_taken}
    // e   = {load[4:0], flush_if_id, flush_id_ex, timeout_err}
    task automatic step(input string tag, input logic [5:0] ctl,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [7:0] e);
        exp_t x;
        exp_t y;
        hz.icache_read = ctl[5];
        hz.icache_resp = ctl[4];
        hz.dcache_req  = ctl[3];
        hz.dcache_resp = ctl[2];
        hz.ex_is_load  = ctl[1];
        hz.ex_br_taken = ctl[0];
        hz.ex_rd       = rd;
        hz.id_rs1      = rs1;
        hz.id_rs2      = rs2;
        x.tag = tag;
        x.ld  = e[7:3];
        x.fi  = e[2];
        x.fe  = e[1];
        x.to  = e[0];
        sb.push_back(x);
        @(negedge clk);
        y = sb.pop_front();
        chk({y.tag, ".load"},     hz.load,                  y.ld);
        chk({y.tag, ".flush_if"}, {4'd0, hz.flush_if_id},   {4'd0, y.fi});
        chk({y.tag, ".flush_ex"}, {4'd0, hz.flush_id_ex},   {4'd0, y.fe});
        chk({y.tag, ".timeout"},  {4'd0, hz.timeout_err},   {4'd0, y.to});
        @(posedge clk);
        #1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        hz.icache_read = 1'b0; hz.icache_resp = 1'b0;
        hz.dcache_req  = 1'b0; hz.dcache_resp = 1'b0;
        hz.ex_is_load  = 1'b0; hz.ex_br_taken = 1'b0;
        hz.ex_rd = 5'd0; hz.id_rs1 = 5'd0; hz.id_rs2 = 5'd0;
        @(posedge clk);
        #1;
        step("rst_hold", 6'b000001, 5'd0, 5'd0, 5'd0, 8'b00000_0_0_0);
        rst = 1'b0;

        // Load-use bubbles
        step("lu_rs2",    6'b110010, 5'd5, 5'd1, 5'd5, 8'b00111_0_1_0);
        step("lu_after",  6'b110000, 5'd0, 5'd0, 5'd0, 8'b11111_0_0_0);
        step("lu_rd0",    6'b110010, 5'd0, 5'd0, 5'd0, 8'b11111_0_0_0);
        step("lu_rs1",    6'b000010, 5'd7, 5'd7, 5'd3, 8'b00111_0_1_0);
        step("lu_noload", 6'b000000, 5'd7, 5'd7, 5'd3, 8'b11111_0_0_0);

        // Icache miss, resp on 5th cycle; load-use is masked by the freeze
        step("ic_miss0",  6'b100000, 5'd0, 5'd0, 5'd0, 8'b00000_0_0_0);
        step("ic_miss1",  6'b100010, 5'd5, 5'd0, 5'd5, 8'b00000_0_0_0);
        for (int i = 0; i < 2; i++)
            step("ic_miss",  6'b100000, 5'd0, 5'd0, 5'd0, 8'b00000_0_0_0);
        step("ic_rel",    6'b110000, 5'd0, 5'd0, 5'd0, 8'b11111_0_0_0);
        step("ic_run",    6'b000000, 5'd0, 5'd0, 5'd0, 8'b11111_0_0_0);

        // Stray response must not pre-satisfy the next fetch
        step("stray",     6'b010000, 5'd0, 5'd0, 5'd0, 8'b11111_0_0_0);
        step("stray_nx",  6'b100000, 5'd0, 5'd0, 5'd0, 8'b00000_0_0_0);
        step("stray_rel", 6'b110000, 5'd0, 5'd0, 5'd0, 8'b11111_0_0_0);

        // Split I/D responses: ic at cycle 2, dc at cycle 6
        step("split1",    6'b101000, 5'd0, 5'd0, 5'd0, 8'b00000_0_0_0);
        step("split2",    6'b111000, 5'd0, 5'd0, 5'd0, 8'b00000_0_0_0);
        for (int i = 0; i < 3; i++)
            step("split_hold", 6'b101000, 5'd0, 5'd0, 5'd0, 8'b00000_0_0_0);
        step("split_rel", 6'b101100, 5'd0, 5'd0, 5'd0, 8'b11111_0_0_0);
        step("split_clr", 6'b100000, 5'd0, 5'd0, 5'd0, 8'b00000_0_0_0);
        step("split_cl2", 6'b110000, 5'd0, 5'd0, 5'd0, 8'b11111_0_0_0);

        // Branch held during dcache miss
        for (int i = 0; i < 3; i++)
            step("br_frz",   6'b001001, 5'd0, 5'd0, 5'd0, 8'b00000_0_0_0);
        step("br_rel",    6'b001101, 5'd0, 5'd0, 5'd0, 8'b11111_1_1_0);
        step("br_after",  6'b000000, 5'd0, 5'd0, 5'd0, 8'b11111_0_0_0);

        // Branch seen only at stall start: pending flush applies on release
        step("pf_frz0",   6'b001001, 5'd0, 5'd0, 5'd0, 8'b00000_0_0_0);
        step("pf_frz1",   6'b001000, 5'd0, 5'd0, 5'd0, 8'b00000_0_0_0);
        step("pf_rel",    6'b001100, 5'd0, 5'd0, 5'd0, 8'b11111_1_1_0);
        step("pf_after",  6'b000000, 5'd0, 5'd0, 5'd0, 8'b11111_0_0_0);

        // Branch beats load-use
        step("br_lu",     6'b110011, 5'd5, 5'd0, 5'd5, 8'b11111_1_1_0);
        step("br_lu_nx",  6'b000000, 5'd0, 5'd0, 5'd0, 8'b11111_0_0_0);

        // Timeout: one miss cycle then nine wait cycles without resp
        step("to_m0",     6'b001000, 5'd0, 5'd0, 5'd0, 8'b00000_0_0_0);
        for (int i = 0; i < 8; i++)
            step("to_wait", 6'b001000, 5'd0, 5'd0, 5'd0, 8'b00000_0_0_0);
        step("to_set",    6'b001000, 5'd0, 5'd0, 5'd0, 8'b00000_0_0_1);
        step("to_rel",    6'b001100, 5'd0, 5'd0, 5'd0, 8'b11111_0_0_1);
        step("to_sticky", 6'b000000, 5'd0, 5'd0, 5'd0, 8'b11111_0_0_1);

        // Reset in the middle of a wait with a pending flush
        step("rw_m0",     6'b001000, 5'd0, 5'd0, 5'd0, 8'b00000_0_0_1);
        step("rw_w1",     6'b001001, 5'd0, 5'd0, 5'd0, 8'b00000_0_0_1);
        rst = 1'b1;
        step("rw_rst",    6'b001001, 5'd0, 5'd0, 5'd0, 8'b00000_0_0_1);
        rst = 1'b0;
        step("rw_run",    6'b000000, 5'd0, 5'd0, 5'd0, 8'b11111_0_0_0);
        step("rw_miss",   6'b001000, 5'd0, 5'd0, 5'd0, 8'b00000_0_0_0);
        step("rw_rel",    6'b001100, 5'd0, 5'd0, 5'd0, 8'b11111_0_0_0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
